// File: rtl/g729_shift_seq.sv
// ---------------------------------------------------------------------------
// g729_shift_seq
// Sequential saturating shifter implementing the G.729 basic ops shl/shr
// (WIDTH=16) and L_shl/L_shr (WIDTH=32). One bit is shifted per clock under a
// start/done handshake. Left shifts saturate to MAX/MIN the moment the next
// step would change the sign bit. Right shifts are arithmetic.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   start        request, sampled only while idle
//   dir          0 = shift left, 1 = shift right
//   var1         signed operand (WIDTH bits)
//   var2         signed shift count (CNT_W bits); negative reverses dir
//   ovf_clear    clears the sticky overflow_acc flag
//   busy         high from start acceptance until done falls
//   done         one-cycle pulse, result/overflow valid
//   result       shifted value, held until the next accepted start completes
//   overflow     saturation occurred in the last operation
//   overflow_acc sticky OR of overflow since the last ovf_clear
// ---------------------------------------------------------------------------
module g729_shift_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] var1,
    input  logic [CNT_W-1:0] var2,
    input  logic             ovf_clear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             overflow_acc
);

    // Count register must hold values up to WIDTH inclusive.
    localparam int CW = $clog2(WIDTH + 1);
    // Magnitude needs one extra bit so that -2^(CNT_W-1) becomes +2^(CNT_W-1).
    localparam int MW = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Saturation value chosen by the sign of the accumulator.
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        logic [WIDTH-1:0] val;
        if (neg) begin
            val = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            val = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return val;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             dir_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             overflow_r;
    logic             overflow_acc_r;

    logic [MW-1:0]    mag_s;
    logic [MW-1:0]    lim_s;
    logic             eff_dir_s;
    logic [CW-1:0]    n_s;
    logic             sat_s;

    // Effective direction and clamped count derived from the signed var2.
    always_comb begin
        mag_s     = '0;
        lim_s     = '0;
        eff_dir_s = dir;
        n_s       = '0;
        if (var2[CNT_W-1]) begin
            mag_s     = {1'b0, ~var2} + MW'(1);
            eff_dir_s = ~dir;
        end else begin
            mag_s     = {1'b0, var2};
            eff_dir_s = dir;
        end
        // Right shifts beyond WIDTH-1 only repeat the sign fill.
        if (eff_dir_s) begin
            lim_s = MW'(WIDTH - 1);
        end else begin
            lim_s = MW'(WIDTH);
        end
        if (mag_s > lim_s) begin
            n_s = lim_s[CW-1:0];
        end else begin
            n_s = mag_s[CW-1:0];
        end
    end

    // A left step saturates when the two top bits differ: the shift would flip the sign.
    always_comb begin
        sat_s = 1'b0;
        if ((state_r == ST_SHIFT) && (cnt_r != '0) && !dir_r) begin
            sat_s = (acc_r[WIDTH-1] != acc_r[WIDTH-2]);
        end else begin
            sat_s = 1'b0;
        end
    end

    // Control FSM, shift datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            acc_r          <= '0;
            cnt_r          <= '0;
            dir_r          <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            result_r       <= '0;
            overflow_r     <= 1'b0;
            overflow_acc_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        acc_r      <= var1;
                        cnt_r      <= n_s;
                        dir_r      <= eff_dir_s;
                        overflow_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == '0) begin
                        result_r <= acc_r;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end else if (sat_s) begin
                        result_r   <= sat_value(acc_r[WIDTH-1]);
                        overflow_r <= 1'b1;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        if (dir_r) begin
                            acc_r <= {acc_r[WIDTH-1], acc_r[WIDTH-1:1]};
                        end else begin
                            acc_r <= {acc_r[WIDTH-2:0], 1'b0};
                        end
                        cnt_r   <= cnt_r - CW'(1);
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase

            // Setting the sticky flag takes priority over clearing it.
            if (sat_s) begin
                overflow_acc_r <= 1'b1;
            end else if (ovf_clear) begin
                overflow_acc_r <= 1'b0;
            end else begin
                overflow_acc_r <= overflow_acc_r;
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign result       = result_r;
    assign overflow     = overflow_r;
    assign overflow_acc = overflow_acc_r;

endmodule

// File: tb/tb_g729_shift_seq.sv
// ---------------------------------------------------------------------------
// tb_g729_shift_seq
// Self-checking bench for g729_shift_seq. Drives a 16-bit and a 32-bit
// instance with a table of known vectors, hand-written handshake/reset
// sequences and random operations checked against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_g729_shift_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start16 = 1'b0;
    logic        start32 = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] var1_16 = 16'h0;
    logic [31:0] var1_32 = 32'h0;
    logic [15:0] var2 = 16'h0;
    logic        ovf_clear = 1'b0;

    logic        busy16, done16, overflow16, ovf_acc16;
    logic [15:0] result16;
    logic        busy32, done32, overflow32, ovf_acc32;
    logic [31:0] result32;

    int vectors = 0;
    int miscompares = 0;
    logic exp_acc16 = 1'b0;
    logic exp_acc32 = 1'b0;

    g729_shift_seq #(.WIDTH(16), .CNT_W(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .dir(dir),
        .var1(var1_16), .var2(var2), .ovf_clear(ovf_clear),
        .busy(busy16), .done(done16), .result(result16),
        .overflow(overflow16), .overflow_acc(ovf_acc16)
    );

    g729_shift_seq #(.WIDTH(32), .CNT_W(16)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .dir(dir),
        .var1(var1_32), .var2(var2), .ovf_clear(ovf_clear),
        .busy(busy32), .done(done32), .result(result32),
        .overflow(overflow32), .overflow_acc(ovf_acc32)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          w;
        logic        d;
        logic [31:0] v1;
        logic [15:0] v2;
        logic [31:0] er;
        logic        eo;
        int          el;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: ITU-T saturating shift computed with plain integer arithmetic.
    function automatic void model(input int w, input logic d, input logic [31:0] v1,
                                  input logic [15:0] v2, output logic [31:0] res,
                                  output logic ov, output int lat);
        longint v, c, r, maxv, minv, p;
        int     n;
        logic   right;
        v = (w == 16) ? longint'($signed(v1[15:0])) : longint'($signed(v1));
        c = longint'($signed(v2));
        right = d;
        if (c < 0) begin
            right = ~d;
            c = -c;
        end
        maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (w - 1));
        ov = 1'b0;
        r = v;
        if (right) begin
            n = (c > longint'(w - 1)) ? (w - 1) : int'(c);
            r = v >>> n;
            lat = n + 1;
        end else begin
            n = (c > longint'(w)) ? w : int'(c);
            lat = n + 1;
            for (int k = 1; k <= n; k++) begin
                p = v * (64'sd1 <<< k);
                if (p > maxv || p < minv) begin
                    r = (v < 0) ? minv : maxv;
                    ov = 1'b1;
                    lat = k;
                    break;
                end
                r = p;
            end
        end
        res = (w == 16) ? {16'h0, r[15:0]} : r[31:0];
    endfunction

    // One complete handshake; checks busy/done framing along the way.
    task automatic run_op(input int w, input logic d, input logic [31:0] v1, input logic [15:0] v2,
                          output logic [31:0] res, output logic ov, output logic oacc, output int lat);
        logic got;
        logic bz;
        @(negedge clock);
        dir = d;
        var2 = v2;
        var1_16 = v1[15:0];
        var1_32 = v1;
        start16 = (w == 16);
        start32 = (w == 32);
        @(posedge clock);
        #1;
        start16 = 1'b0;
        start32 = 1'b0;
        bz = (w == 16) ? busy16 : busy32;
        chk("busy_after_start", {31'd0, bz}, 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 64) begin
            @(posedge clock);
            #1;
            lat++;
            got = (w == 16) ? done16 : done32;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
        res  = (w == 16) ? {16'h0, result16} : result32;
        ov   = (w == 16) ? overflow16 : overflow32;
        oacc = (w == 16) ? ovf_acc16 : ovf_acc32;
        bz   = (w == 16) ? busy16 : busy32;
        chk("busy_with_done", {31'd0, bz}, 32'd1);
        @(posedge clock);
        #1;
        got = (w == 16) ? done16 : done32;
        bz  = (w == 16) ? busy16 : busy32;
        chk("done_one_cycle", {31'd0, got}, 32'd0);
        chk("busy_fall", {31'd0, bz}, 32'd0);
    endtask

    initial begin
        logic [31:0] res, eres, rv1;
        logic [15:0] rv2;
        logic        ov, eov, oacc, rd, got, seen;
        int          lat, elat, rw, cyc;

        tbl[0]  = '{16, 1'b0, 32'h0000_01CC, 16'd6,      32'h0000_7300, 1'b0, 7};
        tbl[1]  = '{16, 1'b0, 32'h0000_000F, 16'd9,      32'h0000_1E00, 1'b0, 10};
        tbl[2]  = '{16, 1'b0, 32'h0000_FC73, 16'd2,      32'h0000_F1CC, 1'b0, 3};
        tbl[3]  = '{16, 1'b0, 32'h0000_4000, 16'd1,      32'h0000_7FFF, 1'b1, 1};
        tbl[4]  = '{16, 1'b0, 32'h0000_C000, 16'd2,      32'h0000_8000, 1'b1, 2};
        tbl[5]  = '{16, 1'b1, 32'h0000_8000, 16'd20,     32'h0000_FFFF, 1'b0, 16};
        tbl[6]  = '{16, 1'b0, 32'h0000_1234, 16'hFFFC,   32'h0000_0123, 1'b0, 5};
        tbl[7]  = '{16, 1'b1, 32'h0000_0001, 16'h8000,   32'h0000_7FFF, 1'b1, 15};
        tbl[8]  = '{16, 1'b0, 32'h0000_0000, 16'd20,     32'h0000_0000, 1'b0, 17};
        tbl[9]  = '{16, 1'b0, 32'h0000_FFFF, 16'd16,     32'h0000_8000, 1'b1, 16};
        tbl[10] = '{16, 1'b1, 32'h0000_4000, 16'd0,      32'h0000_4000, 1'b0, 1};
        tbl[11] = '{32, 1'b0, 32'h0001_0000, 16'd14,     32'h4000_0000, 1'b0, 15};
        tbl[12] = '{32, 1'b0, 32'h0001_0000, 16'd15,     32'h7FFF_FFFF, 1'b1, 15};
        tbl[13] = '{32, 1'b1, 32'hFFFF_0000, 16'd40,     32'hFFFF_FFFF, 1'b0, 32};
        tbl[14] = '{16, 1'b1, 32'h0000_4000, 16'd15,     32'h0000_0000, 1'b0, 16};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy16", {31'd0, busy16}, 32'd0);
        chk("rst_done16", {31'd0, done16}, 32'd0);
        chk("rst_result16", {16'd0, result16}, 32'd0);
        chk("rst_ovf16", {31'd0, overflow16}, 32'd0);
        chk("rst_acc16", {31'd0, ovf_acc16}, 32'd0);
        chk("rst_result32", result32, 32'd0);
        chk("rst_busy32", {31'd0, busy32}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].w, tbl[i].d, tbl[i].v1, tbl[i].v2, res, ov, oacc, lat);
            if (tbl[i].w == 16) exp_acc16 = exp_acc16 | tbl[i].eo;
            else                exp_acc32 = exp_acc32 | tbl[i].eo;
            chk($sformatf("tbl%0d_result", i), res, tbl[i].er);
            chk($sformatf("tbl%0d_ovf", i), {31'd0, ov}, {31'd0, tbl[i].eo});
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].el);
            chk($sformatf("tbl%0d_acc", i), {31'd0, oacc},
                {31'd0, (tbl[i].w == 16) ? exp_acc16 : exp_acc32});
        end

        // Sticky flag: set and clear on the same edge keeps it set
        run_op(16, 1'b0, 32'h0000_4000, 16'd1, res, ov, oacc, lat);
        chk("acc_pre_set", {31'd0, oacc}, 32'd1);
        @(negedge clock);
        dir = 1'b0; var1_16 = 16'h4000; var2 = 16'd1; start16 = 1'b1;
        @(posedge clock);
        #1;
        start16 = 1'b0;
        ovf_clear = 1'b1;
        @(posedge clock);
        #1;
        ovf_clear = 1'b0;
        chk("setclr_done", {31'd0, done16}, 32'd1);
        chk("setclr_ovf", {31'd0, overflow16}, 32'd1);
        chk("setclr_acc", {31'd0, ovf_acc16}, 32'd1);
        exp_acc32 = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        ovf_clear = 1'b1;
        @(negedge clock);
        ovf_clear = 1'b0;
        chk("clr_acc16", {31'd0, ovf_acc16}, 32'd0);
        chk("clr_acc32", {31'd0, ovf_acc32}, 32'd0);
        exp_acc16 = 1'b0;

        // Start while busy is ignored
        @(negedge clock);
        dir = 1'b0; var1_16 = 16'h0001; var2 = 16'd5; start16 = 1'b1;
        @(posedge clock);
        #1;
        start16 = 1'b0;
        @(negedge clock);
        var1_16 = 16'h1111; var2 = 16'd3; start16 = 1'b1;
        @(negedge clock);
        start16 = 1'b0;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
            got = done16;
        end
        chk("busy_start_done_seen", {31'd0, got}, 32'd1);
        chk("busy_start_lat", cyc, 32'd5);
        chk("busy_start_result", {16'd0, result16}, 32'h0000_0020);
        chk("busy_start_ovf", {31'd0, overflow16}, 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
            seen = seen | done16;
        end
        chk("busy_start_no_second_done", {31'd0, seen}, 32'd0);
        chk("busy_start_result_held", {16'd0, result16}, 32'h0000_0020);

        // Reset mid-operation
        run_op(16, 1'b0, 32'h0000_4000, 16'd1, res, ov, oacc, lat);
        chk("prerst_result", res, 32'h0000_7FFF);
        @(negedge clock);
        dir = 1'b0; var1_16 = 16'h0000; var2 = 16'd16; start16 = 1'b1;
        @(posedge clock);
        #1;
        start16 = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy16}, 32'd0);
        chk("midrst_done", {31'd0, done16}, 32'd0);
        chk("midrst_result", {16'd0, result16}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow16}, 32'd0);
        chk("midrst_acc", {31'd0, ovf_acc16}, 32'd0);
        exp_acc16 = 1'b0;
        exp_acc32 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clock);
            #1;
            seen = seen | done16 | busy16;
        end
        chk("midrst_no_done", {31'd0, seen}, 32'd0);

        // Random operations against the model
        for (int i = 0; i < 50; i++) begin
            rw = ($urandom_range(0, 1) == 0) ? 16 : 32;
            rd = 1'($urandom_range(0, 1));
            rv1 = $urandom;
            if ($urandom_range(0, 2) == 0) rv1 = rv1 >> $urandom_range(8, 30);
            case ($urandom_range(0, 3))
                0: rv2 = 16'($urandom_range(0, rw + 2));
                1: rv2 = 16'(-$urandom_range(1, rw + 2));
                2: rv2 = 16'($urandom);
                default: rv2 = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
            endcase
            model(rw, rd, rv1, rv2, eres, eov, elat);
            run_op(rw, rd, rv1, rv2, res, ov, oacc, lat);
            if (rw == 16) exp_acc16 = exp_acc16 | eov;
            else          exp_acc32 = exp_acc32 | eov;
            chk($sformatf("rnd%0d_result", i), res, eres);
            chk($sformatf("rnd%0d_ovf", i), {31'd0, ov}, {31'd0, eov});
            chk($sformatf("rnd%0d_latency", i), lat, elat);
            chk($sformatf("rnd%0d_acc", i), {31'd0, oacc},
                {31'd0, (rw == 16) ? exp_acc16 : exp_acc32});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
